// File: rtl/weight_loader_pkg.sv
// rtl/weight_loader_pkg.sv - shared parameters and state type for the weight buffer loader
package weight_loader_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int LANES      = 9;
  localparam int DEPTH      = 42;
  localparam int BANKS      = 2;
  localparam int ADDR_WIDTH = 12;
  localparam int WORD_WIDTH = DATA_WIDTH * LANES;
  localparam int LANE_W     = 4;
  localparam int ROW_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/weight_lane_packer.sv
// rtl/weight_lane_packer.sv - lane-indexed register file that assembles one RAM word
module weight_lane_packer
  import weight_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [LANE_W-1:0]     lane_o
);

  logic [LANES-1:0][DATA_WIDTH-1:0] lanes_q;
  logic [LANE_W-1:0]                lane_q;

  // Lane count wraps after the last lane so the next row starts at lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (clear_i) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (wr_en_i) begin
      lanes_q[lane_q] <= wr_data_i;
      lane_q          <= (lane_q == LANE_W'(LANES - 1)) ? '0 : lane_q + 1'b1;
    end
  end

  assign word_o = lanes_q;
  assign lane_o = lane_q;

endmodule

// File: rtl/weight_buffer_loader_18_9_42_2.sv
// rtl/weight_buffer_loader_18_9_42_2.sv - streams 18-bit weights into two 162-bit RAM banks
module weight_buffer_loader_18_9_42_2
  import weight_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic [BANKS-1:0]      ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  bank_q, bank_d;
  logic [BANKS-1:0]      we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  logic                  pk_clear;
  logic                  pk_wr;
  logic [WORD_WIDTH-1:0] pk_word;
  logic [LANE_W-1:0]     pk_lane;
  logic [ADDR_WIDTH-1:0] row_addr;

  weight_lane_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (pk_clear),
    .wr_en_i  (pk_wr),
    .wr_data_i(in_data_i),
    .word_o   (pk_word),
    .lane_o   (pk_lane)
  );

  assign row_addr = (bank_q ? ADDR_WIDTH'(DEPTH) : ADDR_WIDTH'(0)) + ADDR_WIDTH'(row_q);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    bank_d   = bank_q;
    we_d     = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    pk_clear = 1'b0;
    pk_wr    = 1'b0;
    if (abort_i) begin
      state_d  = IDLE;
      pk_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = FILL;
            row_d    = '0;
            bank_d   = 1'b0;
            pk_clear = 1'b1;
          end
        end
        FILL: begin
          if (in_valid_i) begin
            pk_wr = 1'b1;
            if (pk_lane == LANE_W'(LANES - 1)) begin
              // Final lane bypasses the packer so the write issues next cycle.
              state_d      = WRITE;
              we_d[bank_q] = 1'b1;
              addr_d       = row_addr;
              data_d       = {in_data_i, pk_word[WORD_WIDTH-DATA_WIDTH-1:0]};
            end
          end
        end
        WRITE: begin
          if (row_q != ROW_W'(DEPTH - 1)) begin
            row_d   = row_q + 1'b1;
            state_d = FILL;
          end else if (!bank_q) begin
            row_d   = '0;
            bank_d  = 1'b1;
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      bank_q  <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o = (state_q == FILL);
  assign busy_o     = (state_q == FILL) || (state_q == WRITE);
  assign done_o     = (state_q == DONE);
  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_data_o = data_q;

endmodule

// File: tb/tb_weight_buffer_loader_18_9_42_2.sv
// tb/tb_weight_buffer_loader_18_9_42_2.sv - directed self-checking bench for the weight loader
module tb_weight_buffer_loader_18_9_42_2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i, in_valid_i;
  logic [17:0]  in_data_i;
  logic         in_ready_o, busy_o, done_o;
  logic [1:0]   ram_we_o;
  logic [11:0]  ram_addr_o;
  logic [161:0] ram_data_o;

  typedef struct {
    logic [1:0]   we;
    logic [11:0]  addr;
    logic [161:0] data;
    int           cyc;
  } wr_t;

  wr_t wr_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;

  weight_buffer_loader_18_9_42_2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .in_valid_i(in_valid_i),
    .in_data_i (in_data_i),
    .in_ready_o(in_ready_o),
    .ram_we_o  (ram_we_o),
    .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [161:0] got, input logic [161:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [161:0] exp_word(input int base, input int w);
    logic [161:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[18*k +: 18] = 18'(base + w * 9 + k);
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (ram_we_o != 2'b00) begin
      wr_q.push_back('{we: ram_we_o, addr: ram_addr_o, data: ram_data_o, cyc: cyc});
      chk("ready_in_write", in_ready_o, 1'b0);
      chk("we_onehot", $onehot(ram_we_o), 1'b1);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    wr_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    #1;
    chk("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic pulse_abort();
    @(negedge clk) abort_i = 1'b1;
    @(negedge clk) abort_i = 1'b0;
    #1;
    chk("busy_after_abort", busy_o, 1'b0);
    chk("ready_after_abort", in_ready_o, 1'b0);
  endtask

  task automatic send_beats(input int first, input int count, input int gap, input int start_at);
    int sent = 0;
    int guard = 0;
    while (sent < count && guard < 5000) begin
      @(negedge clk);
      in_valid_i = ($urandom_range(99) >= gap);
      in_data_i  = 18'(first + sent);
      start_i    = (sent == start_at);
      #1;
      if (in_valid_i && in_ready_o) sent++;
      guard++;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    chk("send_timeout", guard >= 5000, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulses", done_cnt, 1);
    @(negedge clk);
    #1;
    chk("busy_after_done", busy_o, 1'b0);
    chk("done_one_cycle", done_o, 1'b0);
  endtask

  task automatic check_load(input int base);
    chk("n_writes", wr_q.size(), 84);
    for (int w = 0; w < wr_q.size() && w < 84; w++) begin
      chk($sformatf("we_%0d", w), wr_q[w].we, (w < 42) ? 2'b01 : 2'b10);
      chk($sformatf("addr_%0d", w), wr_q[w].addr, w);
      chk($sformatf("data_%0d", w), wr_q[w].data, exp_word(base, w));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, in_ready_o, 1'b0);
    chk({tag, "_we"}, ram_we_o, 2'b00);
    chk({tag, "_addr"}, ram_addr_o, 12'd0);
    chk({tag, "_data"}, ram_data_o, 162'd0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
  endtask

  task automatic check_first_write(input int base);
    repeat (3) @(negedge clk);
    chk("first_n_writes", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      chk("first_we", wr_q[0].we, 2'b01);
      chk("first_addr", wr_q[0].addr, 12'd0);
      chk("first_data", wr_q[0].data, exp_word(base, 0));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Full load, continuous valid
    clear_log();
    pulse_start();
    send_beats(1, 756, 0, -1);
    wait_done();
    check_load(1);
    if (wr_q.size() == 84) begin
      chk("write_spacing", wr_q[83].cyc - wr_q[0].cyc, 830);
      chk("done_latency", done_cyc - wr_q[83].cyc, 1);
      chk("w0_literal", wr_q[0].data, {18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2, 18'd1});
    end

    // Random valid gaps
    clear_log();
    pulse_start();
    send_beats(1, 756, 30, -1);
    wait_done();
    check_load(1);

    // Restart request at row 5 is ignored
    clear_log();
    pulse_start();
    send_beats(1, 756, 0, 45);
    wait_done();
    check_load(1);

    // Abort after lane 4 of bank 0 row 3
    clear_log();
    pulse_start();
    send_beats(1, 32, 0, -1);
    pulse_abort();
    repeat (20) @(negedge clk);
    chk("abort_n_writes", wr_q.size(), 3);
    chk("abort_no_done", done_cnt, 0);
    clear_log();
    pulse_start();
    send_beats(1000, 9, 0, -1);
    check_first_write(1000);
    pulse_abort();

    // Asynchronous reset mid row 10
    clear_log();
    pulse_start();
    send_beats(1, 94, 20, -1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    clear_log();
    pulse_start();
    send_beats(5000, 9, 0, -1);
    check_first_write(5000);
    pulse_abort();

    // start and abort together while idle
    clear_log();
    @(negedge clk) begin start_i = 1'b1; abort_i = 1'b1; end
    @(negedge clk) begin start_i = 1'b0; abort_i = 1'b0; end
    #1;
    chk("sa_busy", busy_o, 1'b0);
    chk("sa_ready", in_ready_o, 1'b0);
    repeat (5) @(negedge clk);
    chk("sa_busy_later", busy_o, 1'b0);
    chk("sa_no_writes", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_buffer_loader_18_9_42_2.md
Name: weight_buffer_loader_18_9_42_2

Overview:
- Write-side companion of the weight buffer ROM reader; the reader takes an index and returns two 162-bit packed rows.
- Accepts a serial valid/ready stream of 18-bit weights and packs 9 lanes per 162-bit word.
- Drives write ports of the two single_port_ram banks (DATA_WIDTH 162, ADDR_WIDTH 12).
- Bank 1 rows land at address 42+row, matching the reader's addrs_base_1 offset; used at configuration time, before inference reads.

Parameters:
- DATA_WIDTH, 18, bits per weight lane
- LANES, 9, weights packed per RAM word (word width = DATA_WIDTH*LANES = 162)
- DEPTH, 42, rows per bank; bank b row r is written at address b*DEPTH + r
- BANKS, 2, number of RAM banks (fixed 2 for this instance)
- ADDR_WIDTH, 12, RAM address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a load; ignored unless idle
- abort  in  1  synchronous cancel; returns to idle, discards the partial word
- in_valid  in  1  stream data valid
- in_data  in  18  weight value
- in_ready  out  1  loader accepts in_data this cycle when in_valid & in_ready
- ram_we  out  2  per-bank write enable, one-hot, registered
- ram_addr  out  12  write address shared by both banks
- ram_data  out  162  packed write word shared by both banks
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, ram_we, ram_addr, ram_data, busy, done = 0; lane, row and bank counters = 0. Reset mid-load discards all progress; RAM contents already written are untouched.
- Stream order: bank 0 rows 0..41, then bank 1 rows 0..41. Within a row, lanes 0..8. Lane k occupies bits [18k+17:18k]. Total 756 accepted beats per load.
- States:
  - IDLE: in_ready=0. start=1 -> FILL, busy=1, counters cleared.
  - FILL: in_ready=1. On each handshake, store in_data in lane `lane` and increment lane. On the handshake at lane==8 -> WRITE. in_valid low holds state; gaps of any length are allowed.
  - WRITE: exactly one cycle.
    - in_ready=0.
    - ram_we[bank]=1, ram_addr=bank*42+row, ram_data=packed word (lane 8 taken directly from the final handshake).
    - Then lane=0. If row<41: row+1 -> FILL. Else if bank==0: row=0, bank=1 -> FILL. Else -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Throughput: 10 cycles per row with continuous valid. First write appears on the cycle after the 9th handshake.
- ram_we is zero in every state except WRITE; ram_addr and ram_data hold their last values otherwise.
- abort, highest priority after reset, in any non-IDLE state: next cycle IDLE, busy=0, no write, no done. An abort in the WRITE cycle still completes that single write.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Address arithmetic: bank*DEPTH+row computed in ADDR_WIDTH bits; max 83, no wrap.

Decomposition:
- Package weight_loader_pkg: DATA_WIDTH, LANES, DEPTH, BANKS, ADDR_WIDTH, WORD_WIDTH=DATA_WIDTH*LANES, state enum {IDLE, FILL, WRITE, DONE}, LANE_W=4, ROW_W=6.
- Sub-module weight_lane_packer:
  - LANES x DATA_WIDTH register file with lane-indexed write and a clear.
  - Exposes the packed word and lane count.
- The FSM, counters and address generation stay in the top module.

Test Plan:
- Full load, in_data = 1..756, valid always high -> 84 writes. First: ram_we=01, addr 0, data = {18'd9,…,18'd1}. Write 43: ram_we=10, addr 42, data lanes 379..387. Last: addr 83. done exactly 10 cycles after write 84 minus 9; then busy=0.
- Random valid gaps (30% low) -> identical write sequence and data as above; in_ready never high in WRITE.
- start pulsed again mid-load (row 5) -> ignored; write count still 84, addresses unchanged.
- abort after lane 4 of bank 0 row 3 -> no further ram_we, done never pulses. New start -> first write is addr 0 containing only the new stream values.
- rst_n low for 1 cycle mid-row 10 -> all outputs 0 immediately (async). Next load writes from addr 0.
- start and abort in the same cycle while IDLE -> remains IDLE, busy stays 0, in_ready 0.
